lcd_cmd_sequencer: RTL and testbench



---
 rtl/lcd_cmd_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: Avalon-MM master for the 16207 character-LCD slave.
// Buffers bytes, runs HD44780 init, stretches E timing, polls busy flag.
module lcd_cmd_sequencer #(
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned E_HIGH_CYCLES  = 25,
    parameter int unsigned E_LOW_CYCLES   = 25,
    parameter int unsigned POWERUP_CYCLES = 750000,
    parameter int unsigned POLL_LIMIT     = 4096,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_is_cmd,
    input  logic [7:0] in_data,
    output logic [1:0] lcd_address,
    output logic       lcd_read,
    output logic       lcd_write,
    output logic       lcd_begintransfer,
    output logic [7:0] lcd_writedata,
    input  logic [7:0] lcd_readdata,
    output logic       init_done,
    output logic       idle,
    output logic       timeout_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] P_ONE = 1;
    localparam logic [AW:0]   C_ONE = 1;

    typedef enum logic [3:0] {
        S_PWRUP, S_INIT_LOAD, S_IDLE, S_SETUP, S_STROBE,
        S_ELOW, S_PSETUP, S_PSTROBE, S_PELOW
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_cnt;
    logic [31:0]   w_limit;
    logic          w_last;
    logic [8:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    r_byte;
    logic          r_is_cmd;
    logic          r_bf;
    logic [31:0]   r_polls;
    logic [1:0]    r_init_idx;
    logic          r_init_done;
    logic          r_timeout;
    logic [7:0]    w_init_byte;
    logic          w_retry;
    logic          w_unused;

    assign w_unused    = ^lcd_readdata[6:0];
    assign w_full      = r_count[AW];
    assign w_empty     = (r_count == '0);
    assign in_ready    = (r_state != S_PWRUP) && !w_full;
    assign w_push      = in_valid && in_ready;
    assign w_pop       = (r_state == S_IDLE) && !w_empty;
    assign idle        = (r_state == S_IDLE) && w_empty;
    assign init_done   = r_init_done;
    assign timeout_err = r_timeout;
    assign w_last      = (r_cnt == w_limit - 32'd1);
    assign w_retry     = r_bf && (r_polls < POLL_LIMIT - 32'd1);

    always_comb begin
        unique case (r_init_idx)
            2'd0: w_init_byte = 8'h38;
            2'd1: w_init_byte = 8'h0C;
            2'd2: w_init_byte = 8'h01;
            2'd3: w_init_byte = 8'h06;
        endcase
    end

    always_comb begin
        w_limit = 32'd1;
        unique case (r_state)
            S_PWRUP:             w_limit = POWERUP_CYCLES;
            S_SETUP, S_PSETUP:   w_limit = SETUP_CYCLES;
            S_STROBE, S_PSTROBE: w_limit = E_HIGH_CYCLES;
            S_ELOW, S_PELOW:     w_limit = E_LOW_CYCLES;
            default:             w_limit = 32'd1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_PWRUP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_state != S_IDLE)
                r_cnt <= r_cnt + 32'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_PWRUP:     if (w_last) w_next = S_INIT_LOAD;
            S_INIT_LOAD: w_next = S_SETUP;
            S_IDLE:      if (!w_empty) w_next = S_SETUP;
            S_SETUP:     if (w_last) w_next = S_STROBE;
            S_STROBE:    if (w_last) w_next = S_ELOW;
            S_ELOW:      if (w_last) w_next = S_PSETUP;
            S_PSETUP:    if (w_last) w_next = S_PSTROBE;
            S_PSTROBE:   if (w_last) w_next = S_PELOW;
            S_PELOW: begin
                if (w_last) begin
                    priority case (1'b1)
                        w_retry:              w_next = S_PSETUP;
                        r_init_done:          w_next = S_IDLE;
                        (r_init_idx == 2'd3): w_next = S_IDLE;
                        default:              w_next = S_INIT_LOAD;
                    endcase
                end
            end
            default:     w_next = S_PWRUP;
        endcase
    end

    always_comb begin
        lcd_address       = 2'b00;
        lcd_writedata     = 8'h00;
        lcd_read          = 1'b0;
        lcd_write         = 1'b0;
        lcd_begintransfer = 1'b0;
        unique case (r_state)
            S_SETUP, S_ELOW: begin
                lcd_address   = {~r_is_cmd, 1'b0};
                lcd_writedata = r_byte;
            end
            S_STROBE: begin
                lcd_address       = {~r_is_cmd, 1'b0};
                lcd_writedata     = r_byte;
                lcd_write         = 1'b1;
                lcd_begintransfer = (r_cnt == 32'd0);
            end
            S_PSETUP, S_PELOW: lcd_address = 2'b01;
            S_PSTROBE: begin
                lcd_address       = 2'b01;
                lcd_read          = 1'b1;
                lcd_begintransfer = (r_cnt == 32'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {in_is_cmd, in_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_byte      <= '0;
            r_is_cmd    <= 1'b0;
            r_bf        <= 1'b0;
            r_polls     <= '0;
            r_init_idx  <= '0;
            r_init_done <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + P_ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + P_ONE;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
            if (r_state == S_INIT_LOAD) begin
                r_byte   <= w_init_byte;
                r_is_cmd <= 1'b1;
                r_polls  <= '0;
            end
            if (w_pop) begin
                {r_is_cmd, r_byte} <= r_mem[r_rd_ptr];
                r_polls            <= '0;
            end
            if (r_state == S_PSTROBE && w_last)
                r_bf <= lcd_readdata[7];
            // A timed-out byte is treated as not busy and the sequence moves on.
            if (r_state == S_PELOW && w_last) begin
                if (w_retry) begin
                    r_polls <= r_polls + 32'd1;
                end else begin
                    if (r_bf)
                        r_timeout <= 1'b1;
                    if (!r_init_done) begin
                        if (r_init_idx == 2'd3)
                            r_init_done <= 1'b1;
                        else
                            r_init_idx <= r_init_idx + 2'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer: bus monitor plus scripted busy-flag slave;
// expected transaction lists come from a per-byte read-count model.
module tb_lcd_cmd_sequencer;
    localparam int PWR = 20;
    localparam int EH  = 4;
    localparam int EL  = 3;
    localparam int SU  = 2;
    localparam int PL  = 8;
    localparam int DEP = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_is_cmd = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [7:0] lcd_readdata = 8'h00;
    logic       in_ready;
    logic [1:0] lcd_address;
    logic       lcd_read;
    logic       lcd_write;
    logic       lcd_begintransfer;
    logic [7:0] lcd_writedata;
    logic       init_done;
    logic       idle;
    logic       timeout_err;

    lcd_cmd_sequencer #(
        .SETUP_CYCLES(SU), .E_HIGH_CYCLES(EH), .E_LOW_CYCLES(EL),
        .POWERUP_CYCLES(PWR), .POLL_LIMIT(PL), .FIFO_DEPTH(DEP)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_cmd(in_is_cmd), .in_data(in_data),
        .lcd_address(lcd_address), .lcd_read(lcd_read),
        .lcd_write(lcd_write), .lcd_begintransfer(lcd_begintransfer),
        .lcd_writedata(lcd_writedata), .lcd_readdata(lcd_readdata),
        .init_done(init_done), .idle(idle), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         wr;
        logic [1:0] addr;
        logic [7:0] data;
        int         cyc;
    } txn_t;

    txn_t       log_q[$];
    txn_t       exp_q[$];
    bit         bf_q[$];
    int         tests = 0;
    int         fails = 0;
    int         viol = 0;
    int         cyc = 0;
    int         wr_len = 0;
    int         rd_len = 0;
    int         gap = 100;
    logic [1:0] cur_addr;
    logic [7:0] cur_data;

    // Monitor and busy-flag slave, sampled away from the active edge.
    always @(negedge clk) begin
        txn_t t;
        bit   b;
        if (!reset_n) begin
            cyc = 0; wr_len = 0; rd_len = 0; gap = 100;
        end else begin
            cyc++;
            if (lcd_read && lcd_write) viol++;
            if (lcd_read || lcd_write) begin
                if (wr_len == 0 && rd_len == 0) begin
                    if (!lcd_begintransfer || gap < EL) viol++;
                    t.wr = lcd_write; t.addr = lcd_address;
                    t.data = lcd_writedata; t.cyc = cyc;
                    log_q.push_back(t);
                    if (lcd_read) begin
                        b = 1'b0;
                        if (bf_q.size() > 0) b = bf_q.pop_front();
                        lcd_readdata = {b, 7'($urandom)};
                    end
                end else begin
                    if (lcd_begintransfer) viol++;
                    if (lcd_address !== cur_addr || lcd_writedata !== cur_data) viol++;
                    if ((lcd_read && wr_len != 0) || (lcd_write && rd_len != 0)) viol++;
                end
                cur_addr = lcd_address; cur_data = lcd_writedata;
                if (lcd_write) wr_len++;
                if (lcd_read) rd_len++;
            end else begin
                if (lcd_begintransfer) viol++;
                if (wr_len + rd_len != 0) begin
                    if (wr_len + rd_len != EH) viol++;
                    gap = 0;
                end
                wr_len = 0; rd_len = 0; gap++;
            end
        end
    end

    // A byte whose slave answers BF=1 k times: one write, then min(k+1, PL) reads.
    task automatic add_byte(input bit cmd, input logic [7:0] d, input int k);
        txn_t t;
        int n;
        n = (k + 1 < PL) ? k + 1 : PL;
        t.wr = 1'b1; t.addr = cmd ? 2'b00 : 2'b10; t.data = d; t.cyc = 0;
        exp_q.push_back(t);
        for (int i = 0; i < n; i++) begin
            t.wr = 1'b0; t.addr = 2'b01; t.data = 8'h00;
            exp_q.push_back(t);
            bf_q.push_back(i < k);
        end
    endtask

    function automatic int first_diff();
        if (log_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) begin
            if (log_q[i].wr !== exp_q[i].wr || log_q[i].addr !== exp_q[i].addr)
                return i;
            if (exp_q[i].wr && log_q[i].data !== exp_q[i].data)
                return i;
        end
        return -1;
    endfunction

    task automatic push(input bit cmd, input logic [7:0] d, output bit ok);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 3000) begin @(negedge clk); n++; end
        ok = in_ready;
        if (ok) begin
            in_valid = 1'b1; in_is_cmd = cmd; in_data = d;
            @(posedge clk); #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (idle !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        ok = (idle === 1'b1);
    endtask

    task automatic wait_init(output bit ok);
        int n = 0;
        while (init_done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        ok = (init_done === 1'b1);
    endtask

    task automatic start_reset();
        reset_n = 1'b0; in_valid = 1'b0;
        log_q.delete(); exp_q.delete(); bf_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        start_reset();
        tests++;
        if ({lcd_read, lcd_write, lcd_begintransfer, lcd_address, lcd_writedata} !== 13'd0) begin
            fails++;
            $display("FAIL reset_bus: got r=%b w=%b bt=%b a=%b d=%h, want all 0",
                     lcd_read, lcd_write, lcd_begintransfer, lcd_address, lcd_writedata);
        end
        tests++;
        if ({init_done, idle, timeout_err, in_ready} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_status: got done/idle/to/rdy=%b%b%b%b, want 0000",
                     init_done, idle, timeout_err, in_ready);
        end
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (10) @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || log_q.size() != 0) begin
            fails++;
            $display("FAIL pwrup_quiet: in_ready=%b txns=%0d, want 0 and 0",
                     in_ready, log_q.size());
        end
    endtask

    task automatic test_init();
        bit ok;
        int d;
        add_byte(1'b1, 8'h38, 0); add_byte(1'b1, 8'h0C, 0);
        add_byte(1'b1, 8'h01, 0); add_byte(1'b1, 8'h06, 0);
        wait_init(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL init_done: got %b, want 1", init_done); end
        d = first_diff();
        tests++;
        if (d != -1) begin
            fails++;
            $display("FAIL init_log: diff at %0d, got %0d txns, want %0d", d, log_q.size(), exp_q.size());
        end
        tests++;
        if (log_q.size() < 2 || log_q[0].cyc <= PWR || log_q[1].cyc - log_q[0].cyc != SU + EH + EL) begin
            fails++;
            $display("FAIL init_timing: first strobe cycle %0d (want >%0d), write-to-read %0d (want %0d)",
                     log_q.size() > 0 ? log_q[0].cyc : -1, PWR,
                     log_q.size() > 1 ? log_q[1].cyc - log_q[0].cyc : -1, SU + EH + EL);
        end
        @(negedge clk);
        tests++;
        if (idle !== 1'b1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL init_idle: idle=%b in_ready=%b, want 1 1", idle, in_ready);
        end
    endtask

    task automatic test_char();
        bit ok;
        int d;
        log_q.delete(); exp_q.delete();
        add_byte(1'b0, 8'h41, 0);
        push(1'b0, 8'h41, ok);
        wait_idle(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL char_idle: idle=%b, want 1", idle); end
        d = first_diff();
        tests++;
        if (d != -1) begin
            fails++;
            $display("FAIL char_log: diff at %0d, got %0d txns, want %0d", d, log_q.size(), exp_q.size());
        end
        tests++;
        if (viol !== 0) begin
            fails++; $display("FAIL char_strobes: %0d violations, want 0", viol); viol = 0;
        end
    endtask

    task automatic test_poll();
        bit ok;
        int d;
        logic [7:0] a, b;
        bit ca, cb;
        log_q.delete(); exp_q.delete();
        a = 8'($urandom); b = 8'($urandom); ca = 1'($urandom); cb = 1'($urandom);
        add_byte(ca, a, 2); add_byte(cb, b, 0);
        push(ca, a, ok); push(cb, b, ok);
        wait_idle(ok);
        d = first_diff();
        tests++;
        if (!ok || d != -1) begin
            fails++;
            $display("FAIL poll_log: idle=%b diff at %0d, got %0d txns, want %0d",
                     idle, d, log_q.size(), exp_q.size());
        end
        tests++;
        if (log_q.size() != 6 || log_q[4].cyc - log_q[0].cyc != 4 * (SU + EH + EL) + 1) begin
            fails++;
            $display("FAIL poll_spacing: write-to-write %0d cycles, want %0d",
                     log_q.size() == 6 ? log_q[4].cyc - log_q[0].cyc : -1, 4 * (SU + EH + EL) + 1);
        end
        tests++;
        if (viol !== 0) begin
            fails++; $display("FAIL poll_strobes: %0d violations, want 0", viol); viol = 0;
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int d;
        logic [7:0] a, b;
        log_q.delete(); exp_q.delete();
        tests++;
        if (timeout_err !== 1'b0) begin
            fails++; $display("FAIL timeout_pre: got %b, want 0", timeout_err);
        end
        a = 8'($urandom); b = 8'($urandom);
        add_byte(1'b0, a, PL); add_byte(1'b1, b, 0);
        push(1'b0, a, ok); push(1'b1, b, ok);
        wait_idle(ok);
        d = first_diff();
        tests++;
        if (!ok || d != -1) begin
            fails++;
            $display("FAIL timeout_log: idle=%b diff at %0d, got %0d txns, want %0d",
                     idle, d, log_q.size(), exp_q.size());
        end
        tests++;
        if (timeout_err !== 1'b1) begin
            fails++; $display("FAIL timeout_flag: got %b, want 1", timeout_err);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d, n, acc;
        logic [7:0] v;
        bit c;
        log_q.delete(); exp_q.delete();
        v = 8'($urandom); c = 1'($urandom);
        add_byte(c, v, 3);
        push(c, v, ok);
        n = 0;
        while (log_q.size() < 2 && n < 3000) begin @(negedge clk); n++; end
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            v = 8'($urandom); c = 1'($urandom);
            in_valid = 1'b1; in_data = v; in_is_cmd = c;
            if (in_ready) begin
                acc++;
                add_byte(c, v, int'($urandom_range(0, 2)));
            end
        end
        @(posedge clk); #1 in_valid = 1'b0;
        tests++;
        if (acc != DEP || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_accept: accepted %0d in_ready=%b, want %0d 0", acc, in_ready, DEP);
        end
        wait_idle(ok);
        d = first_diff();
        tests++;
        if (!ok || d != -1) begin
            fails++;
            $display("FAIL b2b_log: idle=%b diff at %0d, got %0d txns, want %0d",
                     idle, d, log_q.size(), exp_q.size());
        end
        tests++;
        if (timeout_err !== 1'b1 || viol !== 0) begin
            fails++;
            $display("FAIL b2b_sticky: timeout_err=%b violations=%0d, want 1 0", timeout_err, viol);
            viol = 0;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int d, n;
        push(1'b0, 8'($urandom), ok);
        push(1'b0, 8'($urandom), ok);
        push(1'b1, 8'($urandom), ok);
        n = 0;
        while (!(lcd_write && lcd_begintransfer) && n < 3000) begin @(negedge clk); n++; end
        @(posedge clk); #2;
        tests++;
        if (lcd_write !== 1'b1) begin
            fails++; $display("FAIL mid_pre: lcd_write=%b, want 1", lcd_write);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if (lcd_write !== 1'b0) begin
            fails++; $display("FAIL mid_async: lcd_write=%b, want 0", lcd_write);
        end
        start_reset();
        @(posedge clk); #1 reset_n = 1'b1;
        tests++;
        if (timeout_err !== 1'b0 || idle !== 1'b0) begin
            fails++;
            $display("FAIL mid_release: timeout_err=%b idle=%b, want 0 0", timeout_err, idle);
        end
        add_byte(1'b1, 8'h38, 0); add_byte(1'b1, 8'h0C, 0);
        add_byte(1'b1, 8'h01, 0); add_byte(1'b1, 8'h06, 0);
        wait_init(ok);
        repeat (60) @(negedge clk);
        d = first_diff();
        tests++;
        if (!ok || d != -1) begin
            fails++;
            $display("FAIL mid_reinit: done=%b diff at %0d, got %0d txns, want %0d",
                     init_done, d, log_q.size(), exp_q.size());
        end
        tests++;
        if (idle !== 1'b1 || viol !== 0) begin
            fails++;
            $display("FAIL mid_fifo_empty: idle=%b violations=%0d, want 1 0", idle, viol);
        end
    endtask

    initial begin
        lcd_readdata = 8'($urandom) & 8'h7F;
        test_reset();
        test_init();
        test_char();
        test_poll();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end
endmodule
